// File: rtl/tm1638_pkg.sv
// Shared FSM state type and command byte encodings for the TM1638-style serial responder.
package tm1638_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] OP_MASK       = 8'hC0;
  localparam logic [7:0] CMD_DATA      = 8'h40;
  localparam logic [7:0] CMD_DATA_READ = 8'h42;
  localparam logic [7:0] CMD_ADDR      = 8'hC0;
  localparam logic [7:0] CMD_DISP      = 8'h80;

  localparam int unsigned BIT_FIXED   = 2;
  localparam int unsigned BIT_READ    = $clog2(int'(CMD_DATA_READ ^ CMD_DATA));
  localparam int unsigned BIT_DISP_ON = 3;

endpackage

// File: rtl/tm1638_sio_sync.sv
// Multi-flop synchronizer for one serial pin with rise/fall detection on the synchronized level.
module tm1638_sio_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  // chain[STAGES] is the previous synchronized value used for edge detection
  logic [STAGES:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-1:0], din};
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~chain[STAGES];
  assign fall = ~chain[STAGES-1] & chain[STAGES];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638-compatible serial slave: command decode, 16-byte display RAM, key readback and display control.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sio_stb,
  input  logic        sio_clk,
  input  logic        sio_data_in,
  output logic        sio_data_out,
  output logic        sio_data_out_en,
  input  logic [31:0] key_scan,
  input  logic [3:0]  disp_addr,
  output logic [7:0]  disp_data,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr
);

  logic stb_q, stb_rise, stb_fall;
  logic sclk_rise, sclk_fall, unused_sclk_q;
  logic din_q, unused_din_rise, unused_din_fall;

  tm1638_sio_sync #(.STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(clk), .rst(rst), .din(sio_stb), .q(stb_q), .rise(stb_rise), .fall(stb_fall)
  );
  tm1638_sio_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .din(sio_clk), .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  tm1638_sio_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst(rst), .din(sio_data_in), .q(din_q), .rise(unused_din_rise), .fall(unused_din_fall)
  );

  state_t      state, state_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  byte_full;
  logic [3:0]  ptr;
  logic        fixed;
  logic [31:0] keys_sh;
  logic [7:0]  ram [16];

  logic byte_done, do_write, do_keys, do_ptr, do_disp, do_mode;

  assign byte_full = {din_q, shreg[7:1]};
  assign byte_done = sclk_rise & ~stb_q & (bit_cnt == 3'd7);

  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_keys    = 1'b0;
    do_ptr     = 1'b0;
    do_disp    = 1'b0;
    do_mode    = 1'b0;
    if (stb_rise) begin
      state_next = ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (stb_fall) state_next = ST_CMD;
    end else if (byte_done) begin
      case (state)
        ST_CMD: begin
          case (byte_full & OP_MASK)
            CMD_DATA: begin
              do_mode = 1'b1;
              if (byte_full[BIT_READ]) begin
                do_keys    = 1'b1;
                state_next = ST_READ;
              end else begin
                state_next = ST_IGNORE;
              end
            end
            CMD_ADDR: begin
              do_ptr     = 1'b1;
              state_next = ST_WRITE;
            end
            CMD_DISP: begin
              do_disp    = 1'b1;
              state_next = ST_IGNORE;
            end
            default: state_next = ST_IGNORE;
          endcase
        end
        ST_WRITE: do_write = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      ptr             <= '0;
      fixed           <= 1'b0;
      display_on      <= 1'b0;
      brightness      <= '0;
      keys_sh         <= '0;
      sio_data_out    <= 1'b0;
      sio_data_out_en <= 1'b0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
      disp_data       <= '0;
      for (int unsigned i = 0; i < 16; i++) ram[i] <= '0;
    end else begin
      state     <= state_next;
      wr_strobe <= do_write;
      disp_data <= ram[disp_addr];

      // Any stb rise (or idle) discards a partial byte; the stb edge wins over a coincident clk edge
      if (stb_rise || state == ST_IDLE) bit_cnt <= '0;
      else if (sclk_rise) begin
        shreg   <= byte_full;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (do_write) begin
        ram[ptr] <= byte_full;
        wr_addr  <= ptr;
        if (!fixed) ptr <= ptr + 4'd1;
      end
      if (do_ptr)  ptr   <= byte_full[3:0];
      if (do_mode) fixed <= byte_full[BIT_FIXED];
      if (do_disp) begin
        display_on <= byte_full[BIT_DISP_ON];
        brightness <= byte_full[2:0];
      end

      if (stb_rise) begin
        sio_data_out_en <= 1'b0;
        sio_data_out    <= 1'b0;
      end else if (do_keys) begin
        keys_sh         <= key_scan;
        sio_data_out_en <= 1'b1;
      end else if (state == ST_READ && sclk_fall) begin
        sio_data_out <= keys_sh[0];
        keys_sh      <= {1'b0, keys_sh[31:1]};
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Randomized scoreboard bench for tm1638_responder with a command-level reference model.
module tb_tm1638_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sio_stb, sio_clk, sio_data_in;
  logic        sio_data_out, sio_data_out_en;
  logic [31:0] key_scan;
  logic [3:0]  disp_addr;
  logic [7:0]  disp_data;
  logic        display_on;
  logic [2:0]  brightness;
  logic        wr_strobe;
  logic [3:0]  wr_addr;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sio_stb(sio_stb), .sio_clk(sio_clk), .sio_data_in(sio_data_in),
    .sio_data_out(sio_data_out), .sio_data_out_en(sio_data_out_en), .key_scan(key_scan),
    .disp_addr(disp_addr), .disp_data(disp_data), .display_on(display_on),
    .brightness(brightness), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram_m [16];
  logic [3:0] ptr_m;
  logic       fixed_m;
  logic       disp_on_m;
  logic [2:0] bright_m;

  logic [3:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] win  [$];

  logic       reading = 1'b0;
  logic [7:0] rd_bits = '0;
  int         rd_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      if (wr_q.size() == 0) chk("unexpected_wr_strobe", 1, 0);
      else chk("wr_addr", wr_addr, wr_q.pop_front());
    end
  end

  always @(posedge sio_clk) begin
    if (reading) begin
      rd_bits = {sio_data_out, rd_bits[7:1]};
      rd_cnt++;
      if (rd_cnt == 8) begin
        rd_cnt = 0;
        if (rd_q.size() == 0) chk("unexpected_read_byte", 1, 0);
        else chk("read_byte", rd_bits, rd_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sio_clk = 1'b0;
      sio_data_in = b[i];
      wait_clk(8);
      sio_clk = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic stb_low();
    sio_stb = 1'b0;
    wait_clk(8);
  endtask

  task automatic stb_high();
    wait_clk(4);
    sio_stb = 1'b1;
    wait_clk(10);
  endtask

  // Model: one strobe window = command byte plus optional data bytes
  task automatic run_window();
    logic [7:0] cmd;
    cmd = win[0];
    case (cmd[7:6])
      2'b01: fixed_m = cmd[2];
      2'b10: begin disp_on_m = cmd[3]; bright_m = cmd[2:0]; end
      2'b11: ptr_m = cmd[3:0];
      default: ;
    endcase
    stb_low();
    send_bits(cmd, 8);
    for (int k = 1; k < win.size(); k++) begin
      if (cmd[7:6] == 2'b11) begin
        ram_m[ptr_m] = win[k];
        wr_q.push_back(ptr_m);
        if (!fixed_m) ptr_m = ptr_m + 4'd1;
      end
      send_bits(win[k], 8);
    end
    stb_high();
    chk("display_on", display_on, disp_on_m);
    chk("brightness", brightness, bright_m);
  endtask

  task automatic read_window(input logic [31:0] keys, input int n, input logic f);
    logic [7:0] cmd;
    cmd = 8'h42 | {5'b0, f, 2'b0};
    fixed_m = f;
    key_scan = keys;
    for (int k = 0; k < n; k++) rd_q.push_back(k < 4 ? 8'((keys >> (8 * k)) & 32'hFF) : 8'h00);
    stb_low();
    send_bits(cmd, 8);
    reading = 1'b1;
    send_bits(8'h00, 8 * n);
    reading = 1'b0;
    chk("out_en_during_read", sio_data_out_en, 1'b1);
    stb_high();
    chk("out_en_after_stb", sio_data_out_en, 1'b0);
  endtask

  task automatic abort_window(input logic [3:0] a, input int nbits);
    ptr_m = a;
    stb_low();
    send_bits(8'hC0 | {4'b0, a}, 8);
    send_bits(8'hA5, nbits);
    stb_high();
  endtask

  task automatic check_ram();
    for (int a = 0; a < 16; a++) begin
      disp_addr = 4'(a);
      wait_clk(1);
      chk($sformatf("ram[%0d]", a), disp_data, ram_m[a]);
    end
  endtask

  initial begin
    rst = 1'b1; sio_stb = 1'b1; sio_clk = 1'b1; sio_data_in = 1'b0;
    key_scan = '0; disp_addr = '0;
    for (int i = 0; i < 16; i++) ram_m[i] = 8'h00;
    ptr_m = '0; fixed_m = 1'b0; disp_on_m = 1'b0; bright_m = '0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);

    chk("rst_display_on", display_on, 1'b0);
    chk("rst_brightness", brightness, 3'd0);
    chk("rst_data_out", sio_data_out, 1'b0);
    chk("rst_data_out_en", sio_data_out_en, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'd0);
    check_ram();

    win = '{8'h40};             run_window();
    win = '{8'hC0, 8'h3F, 8'h06}; run_window();
    check_ram();

    win = '{8'h44};             run_window();
    win = '{8'hC5, 8'h11, 8'h22}; run_window();
    check_ram();

    win = '{8'h40};             run_window();
    win = '{8'hCF, 8'hAA, 8'hBB}; run_window();
    check_ram();

    read_window(32'h8001_0011, 4, 1'b0);

    win = '{8'h8A};             run_window();

    abort_window(4'd3, 5);
    win = '{8'h8D};             run_window();
    check_ram();

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: win = '{8'h40 | 8'($urandom_range(0, 1) << 2)};
        1: begin
          win = '{8'hC0 | 8'($urandom & 32'h3F)};
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) win.push_back(8'($urandom));
        end
        2: win = '{8'h80 | 8'($urandom & 32'h3F)};
        3: begin
          read_window($urandom, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
          continue;
        end
        default: win = '{8'($urandom & 32'h3F), 8'($urandom)};
      endcase
      run_window();
    end
    check_ram();

    wait_clk(10);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
